// File: rtl/ddr4_train_pkg.sv
// rtl/ddr4_train_pkg.sv - shared types, default constants and helpers for the DQS lane delay trainer
// Purpose: trainer FSM state encoding, default parameter values and the window-width test.
// Ports: none (package).
package ddr4_train_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_CLEAR,
      ST_SAMPLE,
      ST_EVAL,
      ST_STEP,
      ST_CENTER,
      ST_DONE,
      ST_ERR
   } train_state_t;

   localparam int DEF_TAP_W      = 8;
   localparam int DEF_MAX_TAP    = 127;
   localparam int DEF_SETTLE_CYC = 8;
   localparam int DEF_SAMPLE_CYC = 32;
   localparam int DEF_MIN_WIN    = 4;

   // Window width is last-first+1; evaluated at 32 bits so the +1 cannot wrap a TAP_W value.
   function automatic logic win_ok(input logic [31:0] first,
                                   input logic [31:0] last,
                                   input logic [31:0] min_win);
      return (last - first + 32'd1) >= min_win;
   endfunction

endpackage

// File: rtl/ddr4_train_wait_cnt.sv
// rtl/ddr4_train_wait_cnt.sv - loadable down-counter with zero flag for trainer wait phases
// Purpose: times the SETTLE and SAMPLE phases of the trainer (one shared instance).
// Ports: clk, rst (sync active-high), load/load_val (reload), dec (count down, saturates at 0), zero (count==0).
module ddr4_train_wait_cnt #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ddr4_dqs_lane_delay_trainer.sv
// rtl/ddr4_dqs_lane_delay_trainer.sv - per-lane DDR4 DQS read-eye delay trainer
// Purpose: sweeps the IOD delay line from tap 0, samples eye-monitor EARLY/LATE flags at each tap,
//   accepts the first passing window of at least MIN_WIN taps and parks the delay line at its centre.
// Ports: fab_clk/sync_rst (clock, sync active-high reset); train_start/busy/done/err (sequencer handshake);
//   tap_first/tap_last/tap_center (result); delay_line_load/move/direction/out_of_range (IOD delay line);
//   eye_monitor_clear_flags/early/late (IOD eye monitor); eye_map (only with DDR4_TRAIN_EYE_MAP_EN).
// Option: define DDR4_TRAIN_EYE_MAP_EN to add the per-tap pass map output.
module ddr4_dqs_lane_delay_trainer
   import ddr4_train_pkg::*;
#(
   parameter int TAP_W      = DEF_TAP_W,
   parameter int MAX_TAP    = DEF_MAX_TAP,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
   parameter int MIN_WIN    = DEF_MIN_WIN
) (
   input  logic             fab_clk,
   input  logic             sync_rst,
   input  logic             train_start,
   output logic             train_busy,
   output logic             train_done,
   output logic             train_err,
   output logic [TAP_W-1:0] tap_first,
   output logic [TAP_W-1:0] tap_last,
   output logic [TAP_W-1:0] tap_center,
   output logic             delay_line_load,
   output logic             delay_line_move,
   output logic             delay_line_direction,
   input  logic             delay_line_out_of_range,
   output logic             eye_monitor_clear_flags,
   input  logic             eye_monitor_early,
`ifdef DDR4_TRAIN_EYE_MAP_EN
   output logic [MAX_TAP:0] eye_map,
`endif
   input  logic             eye_monitor_late
);

   localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] SAMPLE_VAL = CNT_W'(SAMPLE_CYC - 1);
   localparam logic [TAP_W-1:0] MAX_TAP_T  = TAP_W'(MAX_TAP);
   localparam logic [31:0]      MIN_WIN_U  = 32'(MIN_WIN);

   train_state_t     state, state_n;
   logic [TAP_W-1:0] tap;
   logic             in_win, fail, first_sample, phase, dir;
   logic             early_r, late_r;

   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   logic             pass, in_win_n, win_close, at_end;
   logic [TAP_W-1:0] first_n, last_n, target;
   logic [TAP_W:0]   center_sum;

   ddr4_train_wait_cnt #(.W(CNT_W)) u_wait (
      .clk      (fab_clk),
      .rst      (sync_rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign center_sum = {1'b0, tap_first} + {1'b0, tap_last};
   assign target     = center_sum[TAP_W:1];

   always_comb begin
      state_n                 = state;
      cnt_load                = 1'b0;
      cnt_val                 = SETTLE_VAL;
      cnt_dec                 = 1'b0;
      train_busy              = 1'b1;
      train_done              = 1'b0;
      train_err               = 1'b0;
      delay_line_load         = 1'b0;
      delay_line_move         = 1'b0;
      eye_monitor_clear_flags = 1'b0;

      // Tap evaluation; only consumed in ST_EVAL.
      pass      = !fail;
      first_n   = tap_first;
      last_n    = tap_last;
      in_win_n  = in_win;
      win_close = 1'b0;
      if (pass) begin
         if (!in_win) begin
            first_n  = tap;
            last_n   = tap;
            in_win_n = 1'b1;
         end else begin
            last_n = tap;
         end
      end else if (in_win) begin
         if (win_ok(32'(tap_first), 32'(tap_last), MIN_WIN_U)) win_close = 1'b1;
         else                                                  in_win_n  = 1'b0;
      end
      // A tap flagged out of range still counts as evaluated before the sweep terminates.
      at_end = (tap == MAX_TAP_T) || delay_line_out_of_range;

      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            train_busy = 1'b0;
            train_done = (state == ST_DONE);
            train_err  = (state == ST_ERR);
            if (train_start) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            delay_line_load = 1'b1;
            cnt_load        = 1'b1;
            state_n         = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_zero) state_n = ST_CLEAR;
            else          cnt_dec = 1'b1;
         end
         ST_CLEAR: begin
            eye_monitor_clear_flags = 1'b1;
            cnt_load                = 1'b1;
            cnt_val                 = SAMPLE_VAL;
            state_n                 = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (cnt_zero) state_n = ST_EVAL;
            else          cnt_dec = 1'b1;
         end
         ST_EVAL: begin
            if (win_close)
               state_n = ST_CENTER;
            else if (at_end)
               state_n = (in_win_n && win_ok(32'(first_n), 32'(last_n), MIN_WIN_U)) ? ST_CENTER : ST_ERR;
            else
               state_n = ST_STEP;
         end
         ST_STEP: begin
            // phase 0 shows DIRECTION=1 alone, phase 1 issues the MOVE.
            if (phase) begin
               delay_line_move = 1'b1;
               cnt_load        = 1'b1;
               state_n         = ST_SETTLE;
            end
         end
         ST_CENTER: begin
            // phase 0 decides, phase 1 moves; this spaces MOVEs two cycles apart.
            if (phase)               delay_line_move = 1'b1;
            else if (tap == target)  state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign delay_line_direction = dir;

   always_ff @(posedge fab_clk) begin
      if (sync_rst) begin
         state        <= ST_IDLE;
         tap          <= '0;
         tap_first    <= '0;
         tap_last     <= '0;
         tap_center   <= '0;
         in_win       <= 1'b0;
         fail         <= 1'b0;
         first_sample <= 1'b0;
         phase        <= 1'b0;
         dir          <= 1'b0;
         early_r      <= 1'b0;
         late_r       <= 1'b0;
`ifdef DDR4_TRAIN_EYE_MAP_EN
         eye_map      <= '0;
`endif
      end else begin
         state   <= state_n;
         early_r <= eye_monitor_early;
         late_r  <= eye_monitor_late;
         case (state)
            ST_LOAD: begin
               tap        <= '0;
               tap_first  <= '0;
               tap_last   <= '0;
               tap_center <= '0;
               in_win     <= 1'b0;
               phase      <= 1'b0;
               dir        <= 1'b0;
`ifdef DDR4_TRAIN_EYE_MAP_EN
               eye_map    <= '0;
`endif
            end
            ST_CLEAR: begin
               fail         <= 1'b0;
               first_sample <= 1'b1;
            end
            ST_SAMPLE: begin
               // early_r/late_r in the first SAMPLE cycle still reflect the pre-clear flags.
               first_sample <= 1'b0;
               if (!first_sample) fail <= fail | early_r | late_r;
            end
            ST_EVAL: begin
               tap_first <= first_n;
               tap_last  <= last_n;
               in_win    <= in_win_n;
               phase     <= 1'b0;
               if (state_n == ST_STEP)        dir <= 1'b1;
               else if (state_n == ST_CENTER) dir <= 1'b0;
`ifdef DDR4_TRAIN_EYE_MAP_EN
               for (int t = 0; t <= MAX_TAP; t++)
                  if (tap == TAP_W'(t)) eye_map[t] <= pass;
`endif
            end
            ST_STEP: begin
               phase <= !phase;
               if (phase) tap <= tap + 1'b1;
            end
            ST_CENTER: begin
               if (state_n == ST_DONE) begin
                  tap_center <= tap;
               end else begin
                  phase <= !phase;
                  if (phase) tap <= tap - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr4_dqs_lane_delay_trainer.sv
// tb/tb_ddr4_dqs_lane_delay_trainer.sv - scoreboard testbench for ddr4_dqs_lane_delay_trainer
module tb_ddr4_dqs_lane_delay_trainer;

   logic       fab_clk = 1'b0;
   logic       sync_rst = 1'b1;
   logic       train_start = 1'b0;
   logic       train_busy, train_done, train_err;
   logic [7:0] tap_first, tap_last, tap_center;
   logic       delay_line_load, delay_line_move, delay_line_direction;
   logic       delay_line_out_of_range;
   logic       eye_monitor_clear_flags, eye_monitor_early, eye_monitor_late;
`ifdef DDR4_TRAIN_EYE_MAP_EN
   logic [127:0] eye_map;
`endif

   always #5 fab_clk = ~fab_clk;

   ddr4_dqs_lane_delay_trainer dut (
      .fab_clk                 (fab_clk),
      .sync_rst                (sync_rst),
      .train_start             (train_start),
      .train_busy              (train_busy),
      .train_done              (train_done),
      .train_err               (train_err),
      .tap_first               (tap_first),
      .tap_last                (tap_last),
      .tap_center              (tap_center),
      .delay_line_load         (delay_line_load),
      .delay_line_move         (delay_line_move),
      .delay_line_direction    (delay_line_direction),
      .delay_line_out_of_range (delay_line_out_of_range),
      .eye_monitor_clear_flags (eye_monitor_clear_flags),
      .eye_monitor_early       (eye_monitor_early),
`ifdef DDR4_TRAIN_EYE_MAP_EN
      .eye_map                 (eye_map),
`endif
      .eye_monitor_late        (eye_monitor_late)
   );

   // IOD behavioural model: delay line position plus eye flags around a window (and optional glitch).
   int  model_tap = 0;
   int  w_lo = 1000, w_hi = 1000, g_lo = -1, g_hi = -1, oor_tap = 1000;
   bit  tap_ok;

   always @(posedge fab_clk) begin
      if (delay_line_load)      model_tap <= 0;
      else if (delay_line_move) model_tap <= delay_line_direction ? model_tap + 1 : model_tap - 1;
   end

   assign tap_ok = (model_tap >= g_lo && model_tap <= g_hi) || (model_tap >= w_lo && model_tap <= w_hi);
   assign eye_monitor_early       = !tap_ok && (model_tap < w_lo);
   assign eye_monitor_late        = !tap_ok && (model_tap >= w_lo);
   assign delay_line_out_of_range = (model_tap >= oor_tap);

   typedef struct {
      int done;
      int err;
      int first;
      int last;
      int center;
      int ptap;
      int inc;
      int dec;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   task automatic push_exp(input int d, input int e, input int f, input int l,
                           input int c, input int pt, input int inc, input int dec);
      exp_t x;
      x.done = d; x.err = e; x.first = f; x.last = l;
      x.center = c; x.ptap = pt; x.inc = inc; x.dec = dec;
      exp_q.push_back(x);
   endtask

   task automatic set_cfg(input int glo, input int ghi, input int lo, input int hi, input int oor);
      g_lo = glo; g_hi = ghi; w_lo = lo; w_hi = hi; oor_tap = oor;
   endtask

   task automatic start_pulse();
      @(negedge fab_clk);
      train_start = 1'b1;
      @(negedge fab_clk);
      train_start = 1'b0;
   endtask

   task automatic wait_result();
      int n = 0;
      while (!(train_done || train_err) && n < 20000) begin
         @(negedge fab_clk);
         n++;
      end
      if (!(train_done || train_err)) check("result_timeout", 0, 1);
      repeat (3) @(negedge fab_clk);
   endtask

   // Monitor: counts MOVEs, checks DIRECTION stability, pops and compares on each new result.
   initial begin
      int   inc_cnt = 0;
      int   dec_cnt = 0;
      int   dir_viol = 0;
      logic dir_prev = 1'b0;
      logic fin_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge fab_clk);
         if (delay_line_load) begin
            inc_cnt = 0; dec_cnt = 0; dir_viol = 0;
         end
         if (delay_line_move) begin
            if (delay_line_direction !== dir_prev) dir_viol++;
            if (delay_line_direction) inc_cnt++;
            else                      dec_cnt++;
         end
         if ((train_done || train_err) && !fin_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("done",       int'(train_done), e.done);
               check("err",        int'(train_err),  e.err);
               check("busy",       int'(train_busy), 0);
               check("tap_first",  int'(tap_first),  e.first);
               check("tap_last",   int'(tap_last),   e.last);
               check("tap_center", int'(tap_center), e.center);
               check("iod_tap",    model_tap,        e.ptap);
               check("inc_moves",  inc_cnt,          e.inc);
               check("dec_moves",  dec_cnt,          e.dec);
               check("dir_stable", dir_viol,         0);
            end
         end
         fin_prev = train_done || train_err;
         dir_prev = delay_line_direction;
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge fab_clk);
      check("reset_outputs", int'({train_busy, train_done, train_err, tap_first, tap_last, tap_center,
                                   delay_line_load, delay_line_move, delay_line_direction,
                                   eye_monitor_clear_flags}), 0);
      sync_rst = 1'b0;

      // 1: window 20..40
      set_cfg(-1, -1, 20, 40, 1000);
      push_exp(1, 0, 20, 40, 30, 30, 41, 11);
      start_pulse();
      wait_result();

      // 2: no passing tap
      set_cfg(-1, -1, 1000, 1000, 1000);
      push_exp(0, 1, 0, 0, 0, 127, 127, 0);
      start_pulse();
      wait_result();

      // 3: short glitch 5..6 then window 50..70
      set_cfg(5, 6, 50, 70, 1000);
      push_exp(1, 0, 50, 70, 60, 60, 71, 11);
      start_pulse();
      wait_result();

      // 4: window from 80, delay line out of range at 90
      set_cfg(-1, -1, 80, 200, 90);
      push_exp(1, 0, 80, 90, 85, 85, 90, 5);
      start_pulse();
      wait_result();

      // 5: reset while sampling, then restart
      set_cfg(-1, -1, 20, 40, 1000);
      push_exp(1, 0, 20, 40, 30, 30, 41, 11);
      start_pulse();
      n = 0;
      while (!eye_monitor_clear_flags && n < 2000) begin
         @(negedge fab_clk);
         n++;
      end
      check("s5_reached_clear", int'(eye_monitor_clear_flags), 1);
      repeat (5) @(negedge fab_clk);
      sync_rst = 1'b1;
      @(negedge fab_clk);
      check("s5_reset_outputs", int'({train_busy, train_done, train_err, tap_first, tap_last, tap_center,
                                      delay_line_load, delay_line_move, delay_line_direction,
                                      eye_monitor_clear_flags}), 0);
      sync_rst    = 1'b0;
      train_start = 1'b1;
      @(negedge fab_clk);
      train_start = 1'b0;
      check("s5_load_pulse", int'(delay_line_load), 1);
      check("s5_busy", int'(train_busy), 1);
      wait_result();

      // 6: START pulses while busy are ignored
      set_cfg(-1, -1, 20, 40, 1000);
      push_exp(1, 0, 20, 40, 30, 30, 41, 11);
      start_pulse();
      repeat (3) @(negedge fab_clk);
      start_pulse();
      repeat (600) @(negedge fab_clk);
      start_pulse();
      wait_result();

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
